calc_core: RTL
==============

# calc_core

Parametrised calculator control-and-datapath core: the successor to the fixed 8-bit calculator top. It accepts operands and an opcode through an Enter/Clear button protocol and computes the result with its own ALU, and it reports flags and an error state. Result chaining is supported. It sits between the debounced switch/button inputs and the BCD/seven-segment display chain, which consumes `a_out`, `b_out`, `result_out` and `leds`.

## Interface
- `WIDTH`, 8: operand/result width in bits (≥ 2).
- `clock`  in  1  system clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `data_in`  in  WIDTH  operand value from the switches.
- `op_in`  in  4  opcode from the switches.
- `enter`  in  1  Enter button level (debounced); acts on its rising edge.
- `clear`  in  1  Clear button level (debounced); acts on its rising edge.
- `a_out`  out  WIDTH  registered operand A.
- `b_out`  out  WIDTH  registered operand B.
- `result_out`  out  WIDTH  registered result.
- `zero`, `carry`, `overflow`  out  1 each  registered result flags.
- `error`  out  1  high while in ERROR.
- `result_valid`  out  1  one-cycle pulse on the cycle RESULT is entered.
- `leds`  out  4  state indicator.

## Operation
- Edge detect: `enter_q`/`clear_q` register the previous cycle's input levels. `enter_p = enter & ~enter_q`, and `clear_p` is formed the same way. A held button acts once.
- States: IDLE, WITH_A, WITH_B, RESULT, ERROR. `leds`: IDLE 0001, WITH_A 0011, WITH_B 0111, RESULT 1111, ERROR 1000.
- IDLE + `enter_p`: A←`data_in`, go to WITH_A. `clear_p` has no effect in IDLE.
- WITH_A + `enter_p`: B←`data_in`, go to WITH_B.
- WITH_B + `enter_p`:
  - Opcode 0–9: latch op, write `result_out`/flags, pulse `result_valid`, go to RESULT.
  - Opcode 10–15: go to ERROR, leave `result_out`/flags unchanged.
- RESULT + `enter_p`: A←`result_out`, B←0, flags←0, go to WITH_A (chaining). `result_out` holds its value.
- ERROR: `enter_p` is ignored. Only `clear_p` (or `reset`) exits.
- `clear_p` in WITH_A, WITH_B, RESULT or ERROR clears A, B, `result_out` and all flags, then goes to IDLE.
- If `enter_p` and `clear_p` occur in the same cycle, clear wins.
- Opcodes:
  - 0 ADD: A+B; carry = bit WIDTH of the sum; overflow = signed overflow.
  - 1 SUB: A−B; carry = borrow (A<B unsigned); overflow = signed overflow.
  - 2 AND, 3 OR, 4 XOR: carry = 0, overflow = 0.
  - 5 NOT A: carry = 0, overflow = 0.
  - 6 SHL A by 1: carry = A[WIDTH−1]; overflow = A[WIDTH−1] ^ A[WIDTH−2].
  - 7 SHR A logical by 1: carry = A[0]; overflow = 0.
  - 8 INC A: carry = (A == all ones); overflow = (A == 0111…1).
  - 9 DEC A: carry = (A == 0); overflow = (A == 1000…0).
  - All results are truncated to WIDTH bits.
- `zero` = (truncated result == 0).

## Timing
- Reset (checked at rising edge): state IDLE, all outputs 0 except `leds` = 0001. `enter_q` and `clear_q` are loaded with the current `enter`/`clear` levels, so a button held through reset does not fire.
- Reset mid-operation overrides everything in the same edge.
- Latency: the first edge with `enter` = 1 after a low sample updates state and registers on that same edge. Outputs are valid in the following cycle. Result computation is single-cycle, with no pipeline.
- `result_valid` is high for exactly one cycle after the WITH_B→RESULT edge and never in any other case.
- All outputs are registered; no combinational path runs from inputs to outputs.
- A button must be low for at least one sampled cycle between presses to register a second press.

## Test plan
- WIDTH = 8, reset, then press Enter with 100, Enter with 27, Enter with op 0 → `result_out` = 127, zero = 0, carry = 0, overflow = 0, `leds` 1111, one `result_valid` pulse.
- Enter 200, Enter 100, op 0 → `result_out` = 44, carry = 1, overflow = 0. Enter again → A = 44, B = 0, state WITH_A, `leds` 0011.
- Enter 5, Enter 9, op 1 → `result_out` = 252, carry = 1. Then enter 127 with op 8 (INC) → `result_out` = 128, overflow = 1, carry = 0.
- Enter 3, Enter 4, op 12 → ERROR, `error` = 1, `leds` 1000. Enter is ignored. Clear → IDLE, all outputs 0, `leds` 0001.
- Enter held high for 10 cycles in IDLE → exactly one transition, to WITH_A. Enter and Clear rising together in WITH_B → IDLE.
- Reset asserted while in WITH_B with A = 55 → next cycle IDLE, A = 0, `leds` 0001. Repeat the ADD scenario with WIDTH = 16: 40000 + 30000 → 4464, carry = 1.

Source files
------------

// File: rtl/calc_core.sv
// Calculator control-and-datapath core: Enter/Clear button protocol, single-cycle ALU,
// registered operands, result, flags and state indicator with result chaining.
module calc_core #(
   parameter int WIDTH = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] data_in,
   input  logic [3:0]       op_in,
   input  logic             enter,
   input  logic             clear,
   output logic [WIDTH-1:0] a_out,
   output logic [WIDTH-1:0] b_out,
   output logic [WIDTH-1:0] result_out,
   output logic             zero,
   output logic             carry,
   output logic             overflow,
   output logic             error,
   output logic             result_valid,
   output logic [3:0]       leds
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WITH_A,
      S_WITH_B,
      S_RESULT,
      S_ERROR
   } state_t;

   localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0] MAX_POS  = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic             zero_q, zero_d;
   logic             carry_q, carry_d;
   logic             ovf_q, ovf_d;
   logic             rv_q, rv_d;
   logic             err_q, err_d;
   logic [3:0]       leds_q, leds_d;
   logic             enter_q, clear_q;

   logic             enter_p, clear_p;
   logic [WIDTH:0]   sum_w, dif_w;
   logic [WIDTH-1:0] alu_res;
   logic             alu_c, alu_v, alu_z;

   assign enter_p = enter & ~enter_q;
   assign clear_p = clear & ~clear_q;

   // ALU works on the stored operands and the opcode presented with the third press.
   always_comb begin
      alu_res = '0;
      alu_c   = 1'b0;
      alu_v   = 1'b0;
      sum_w   = {1'b0, a_q} + {1'b0, b_q};
      dif_w   = {1'b0, a_q} - {1'b0, b_q};
      case (op_in)
         4'd0: begin
            alu_res = sum_w[WIDTH-1:0];
            alu_c   = sum_w[WIDTH];
            alu_v   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum_w[WIDTH-1] != a_q[WIDTH-1]);
         end
         4'd1: begin
            alu_res = dif_w[WIDTH-1:0];
            alu_c   = dif_w[WIDTH];
            alu_v   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (dif_w[WIDTH-1] != a_q[WIDTH-1]);
         end
         4'd2: alu_res = a_q & b_q;
         4'd3: alu_res = a_q | b_q;
         4'd4: alu_res = a_q ^ b_q;
         4'd5: alu_res = ~a_q;
         4'd6: begin
            alu_res = {a_q[WIDTH-2:0], 1'b0};
            alu_c   = a_q[WIDTH-1];
            alu_v   = a_q[WIDTH-1] ^ a_q[WIDTH-2];
         end
         4'd7: begin
            alu_res = {1'b0, a_q[WIDTH-1:1]};
            alu_c   = a_q[0];
         end
         4'd8: begin
            alu_res = a_q + 1'b1;
            alu_c   = (a_q == ALL_ONES);
            alu_v   = (a_q == MAX_POS);
         end
         4'd9: begin
            alu_res = a_q - 1'b1;
            alu_c   = (a_q == '0);
            alu_v   = (a_q == MIN_NEG);
         end
         default: begin
            alu_res = '0;
            alu_c   = 1'b0;
            alu_v   = 1'b0;
         end
      endcase
      alu_z = (alu_res == '0);
   end

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;
      zero_d  = zero_q;
      carry_d = carry_q;
      ovf_d   = ovf_q;
      rv_d    = 1'b0;
      // Clear has no meaning in IDLE, so there it neither acts nor masks Enter.
      if (clear_p && (state_q != S_IDLE)) begin
         state_d = S_IDLE;
         a_d     = '0;
         b_d     = '0;
         res_d   = '0;
         zero_d  = 1'b0;
         carry_d = 1'b0;
         ovf_d   = 1'b0;
      end else if (enter_p) begin
         case (state_q)
            S_IDLE: begin
               a_d     = data_in;
               state_d = S_WITH_A;
            end
            S_WITH_A: begin
               b_d     = data_in;
               state_d = S_WITH_B;
            end
            S_WITH_B: begin
               if (op_in <= 4'd9) begin
                  res_d   = alu_res;
                  zero_d  = alu_z;
                  carry_d = alu_c;
                  ovf_d   = alu_v;
                  rv_d    = 1'b1;
                  state_d = S_RESULT;
               end else begin
                  state_d = S_ERROR;
               end
            end
            S_RESULT: begin
               a_d     = res_q;
               b_d     = '0;
               zero_d  = 1'b0;
               carry_d = 1'b0;
               ovf_d   = 1'b0;
               state_d = S_WITH_A;
            end
            default: state_d = state_q;
         endcase
      end
   end

   // Indicator outputs are decoded from the next state so they stay registered.
   always_comb begin
      err_d = (state_d == S_ERROR);
      case (state_d)
         S_IDLE:   leds_d = 4'b0001;
         S_WITH_A: leds_d = 4'b0011;
         S_WITH_B: leds_d = 4'b0111;
         S_RESULT: leds_d = 4'b1111;
         S_ERROR:  leds_d = 4'b1000;
         default:  leds_d = 4'b0001;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= S_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         zero_q  <= 1'b0;
         carry_q <= 1'b0;
         ovf_q   <= 1'b0;
         rv_q    <= 1'b0;
         err_q   <= 1'b0;
         leds_q  <= 4'b0001;
         // A button held through reset must not fire on release of reset.
         enter_q <= enter;
         clear_q <= clear;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         zero_q  <= zero_d;
         carry_q <= carry_d;
         ovf_q   <= ovf_d;
         rv_q    <= rv_d;
         err_q   <= err_d;
         leds_q  <= leds_d;
         enter_q <= enter;
         clear_q <= clear;
      end
   end

   assign a_out        = a_q;
   assign b_out        = b_q;
   assign result_out   = res_q;
   assign zero         = zero_q;
   assign carry        = carry_q;
   assign overflow     = ovf_q;
   assign error        = err_q;
   assign result_valid = rv_q;
   assign leds         = leds_q;

endmodule
